// File: rtl/hatch_cpu.sv
// hatch_cpu: single-cycle stack-machine core.
// Fetches 48-bit bytecode over the hatch port.
module hatch_cpu #(
  parameter int DS_DEPTH   = 64,
  parameter int CS_DEPTH   = 16,
  parameter int INSN_BYTES = 6
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [47:0] hatch_instruction,
  output logic [31:0] hatch_address
);

  localparam int SPW = $clog2(DS_DEPTH) + 1;
  localparam int AW  = $clog2(DS_DEPTH);
  localparam int CSW = $clog2(CS_DEPTH) + 1;
  localparam int CAW = $clog2(CS_DEPTH);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_PUSH   = 8'h01;
  localparam logic [7:0] OP_POP    = 8'h02;
  localparam logic [7:0] OP_RETURN = 8'h05;
  localparam logic [7:0] OP_GOTO   = 8'h06;
  localparam logic [7:0] OP_IFEQ   = 8'h07;
  localparam logic [7:0] OP_IFNE   = 8'h08;
  localparam logic [7:0] OP_ADD    = 8'h10;
  localparam logic [7:0] OP_SUB    = 8'h11;
  localparam logic [7:0] OP_BITAND = 8'h12;
  localparam logic [7:0] OP_BITOR  = 8'h13;
  localparam logic [7:0] OP_BITXOR = 8'h14;
  localparam logic [7:0] OP_EQ     = 8'h15;
  localparam logic [7:0] OP_LT     = 8'h16;
  localparam logic [7:0] OP_DUP    = 8'h17;
  localparam logic [7:0] OP_CALL   = 8'h3A;

  logic [31:0]    r_pc;
  logic [SPW-1:0] r_sp;
  logic [CSW-1:0] r_csp;
  logic           r_halted;
  logic           r_fault;

  logic [31:0]    r_ds      [DS_DEPTH];
  logic [31:0]    r_cs_ret  [CS_DEPTH];
  logic [SPW-1:0] r_cs_base [CS_DEPTH];

  logic [7:0]     w_op;
  logic [31:0]    w_arg;
  logic [31:0]    w_pc_inc;
  logic [SPW-1:0] w_sp_m1;
  logic [SPW-1:0] w_sp_m2;
  logic [SPW-1:0] w_sp_p1;
  logic [CSW-1:0] w_csp_m1;
  logic [31:0]    w_top;
  logic [31:0]    w_sec;
  logic [31:0]    w_frame_ret;
  logic [SPW-1:0] w_frame_base;
  logic [SPW-1:0] w_call_base;
  logic [31:0]    w_call_tgt;
  logic           w_ds_full;
  logic           w_cs_full;
  logic           w_call_ok;
  logic [31:0]    w_alu;

  logic           w_is_push;
  logic           w_is_pop;
  logic           w_is_ret;
  logic           w_is_goto;
  logic           w_is_br;
  logic           w_is_alu;
  logic           w_is_dup;
  logic           w_is_call;

  logic [31:0]    w_pc_nxt;
  logic [SPW-1:0] w_sp_nxt;
  logic [CSW-1:0] w_csp_nxt;
  logic           w_ds_we;
  logic [AW-1:0]  w_ds_wa;
  logic [31:0]    w_ds_wd;
  logic           w_cs_we;
  logic           w_halt;
  logic           w_fault;
  logic           w_commit;
  logic           w_unused;

  assign w_op     = hatch_instruction[47:40];
  assign w_arg    = hatch_instruction[31:0];
  assign w_pc_inc = r_pc + 32'(INSN_BYTES);

  assign w_sp_m1  = r_sp - SPW'(1);
  assign w_sp_m2  = r_sp - SPW'(2);
  assign w_sp_p1  = r_sp + SPW'(1);
  assign w_csp_m1 = r_csp - CSW'(1);

  assign w_top = r_ds[w_sp_m1[AW-1:0]];
  assign w_sec = r_ds[w_sp_m2[AW-1:0]];

  assign w_frame_ret  = r_cs_ret[w_csp_m1[CAW-1:0]];
  assign w_frame_base = r_cs_base[w_csp_m1[CAW-1:0]];

  assign w_call_ok   = w_arg < 32'(r_sp);
  assign w_call_base = r_sp - w_arg[SPW-1:0] - SPW'(1);
  assign w_call_tgt  = r_ds[w_call_base[AW-1:0]];

  assign w_ds_full = r_sp == SPW'(DS_DEPTH);
  assign w_cs_full = r_csp == CSW'(CS_DEPTH);

  assign w_is_push = w_op == OP_PUSH;
  assign w_is_pop  = w_op == OP_POP;
  assign w_is_ret  = w_op == OP_RETURN;
  assign w_is_goto = w_op == OP_GOTO;
  assign w_is_br   = (w_op == OP_IFEQ) || (w_op == OP_IFNE);
  assign w_is_alu  = (w_op >= OP_ADD) && (w_op <= OP_LT);
  assign w_is_dup  = w_op == OP_DUP;
  assign w_is_call = w_op == OP_CALL;

  // Binary operator result: a = second, b = top.
  always_comb begin
    w_alu = 32'h0;
    case (w_op)
      OP_ADD:    w_alu = w_sec + w_top;
      OP_SUB:    w_alu = w_sec - w_top;
      OP_BITAND: w_alu = w_sec & w_top;
      OP_BITOR:  w_alu = w_sec | w_top;
      OP_BITXOR: w_alu = w_sec ^ w_top;
      OP_EQ:     w_alu = {31'h0, w_sec == w_top};
      OP_LT:     w_alu = {31'h0, $signed(w_sec) < $signed(w_top)};
      default:   w_alu = 32'h0;
    endcase
  end

  // Decode/execute: next PC, pointers, stack writes, faults.
  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_sp_nxt  = r_sp;
    w_csp_nxt = r_csp;
    w_ds_we   = 1'b0;
    w_ds_wa   = r_sp[AW-1:0];
    w_ds_wd   = w_arg;
    w_cs_we   = 1'b0;
    w_halt    = 1'b0;
    w_fault   = 1'b0;
    unique case (1'b1)
      w_is_push: begin
        if (w_ds_full) begin
          w_fault = 1'b1;
        end else begin
          w_ds_we  = 1'b1;
          w_sp_nxt = w_sp_p1;
        end
      end
      w_is_pop: begin
        if (r_sp == '0) w_fault  = 1'b1;
        else            w_sp_nxt = w_sp_m1;
      end
      w_is_ret: begin
        if (r_csp == '0) begin
          w_halt = 1'b1;
        end else if (r_sp <= w_frame_base) begin
          w_fault = 1'b1;
        end else begin
          w_ds_we   = 1'b1;
          w_ds_wa   = w_frame_base[AW-1:0];
          w_ds_wd   = w_top;
          w_sp_nxt  = w_frame_base + SPW'(1);
          w_csp_nxt = w_csp_m1;
          w_pc_nxt  = w_frame_ret;
        end
      end
      w_is_goto: begin
        w_pc_nxt = w_arg;
      end
      w_is_br: begin
        if (r_sp == '0) begin
          w_fault = 1'b1;
        end else begin
          w_sp_nxt = w_sp_m1;
          if ((w_op == OP_IFEQ) == (w_top == 32'h0))
            w_pc_nxt = w_arg;
        end
      end
      w_is_alu: begin
        if (r_sp < SPW'(2)) begin
          w_fault = 1'b1;
        end else begin
          w_ds_we  = 1'b1;
          w_ds_wa  = w_sp_m2[AW-1:0];
          w_ds_wd  = w_alu;
          w_sp_nxt = w_sp_m1;
        end
      end
      w_is_dup: begin
        if (r_sp == '0 || w_ds_full) begin
          w_fault = 1'b1;
        end else begin
          w_ds_we  = 1'b1;
          w_ds_wd  = w_top;
          w_sp_nxt = w_sp_p1;
        end
      end
      w_is_call: begin
        if (!w_call_ok || w_cs_full) begin
          w_fault = 1'b1;
        end else begin
          w_cs_we   = 1'b1;
          w_csp_nxt = r_csp + CSW'(1);
          w_pc_nxt  = w_call_tgt;
        end
      end
      default: begin
        w_pc_nxt = w_pc_inc;
      end
    endcase
  end

  assign w_commit = rst_b && !r_halted && !w_fault && !w_halt;

  // Architectural state: PC, pointers, halt/fault flags.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pc     <= 32'h0;
      r_sp     <= '0;
      r_csp    <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else if (!r_halted) begin
      if (w_fault) begin
        r_halted <= 1'b1;
        r_fault  <= 1'b1;
      end else if (w_halt) begin
        r_halted <= 1'b1;
      end else begin
        r_pc  <= w_pc_nxt;
        r_sp  <= w_sp_nxt;
        r_csp <= w_csp_nxt;
      end
    end
  end

  // Data stack storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_ds_we)
      r_ds[w_ds_wa] <= w_ds_wd;
  end

  // Call stack frames (return PC, frame base); not reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_cs_we) begin
      r_cs_ret[r_csp[CAW-1:0]]  <= w_pc_inc;
      r_cs_base[r_csp[CAW-1:0]] <= w_call_base;
    end
  end

  assign hatch_address = r_pc;

  assign w_unused = ^{hatch_instruction[39:32], r_fault, w_sp_m2[SPW-1], OP_NOP};

endmodule

// File: tb/tb_hatch_cpu.sv
// tb_hatch_cpu: directed vectors plus random bytecode
// checked against a queue-based stack-machine model.
module tb_hatch_cpu;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [47:0] hatch_instruction;
  logic [31:0] hatch_address;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hatch_cpu dut (
    .clk               (clk),
    .rst_b             (rst_b),
    .hatch_instruction (hatch_instruction),
    .hatch_address     (hatch_address)
  );

  localparam logic [7:0] NOP = 8'h00, PUSH = 8'h01, POP = 8'h02;
  localparam logic [7:0] RET = 8'h05, GOTO = 8'h06;
  localparam logic [7:0] IFEQ = 8'h07, IFNE = 8'h08;
  localparam logic [7:0] ADD = 8'h10, SUB = 8'h11, BAND = 8'h12;
  localparam logic [7:0] BOR = 8'h13, BXOR = 8'h14;
  localparam logic [7:0] EQ = 8'h15, LT = 8'h16, DUP = 8'h17;
  localparam logic [7:0] CALL = 8'h3A;

  typedef struct {
    logic [47:0] insn;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] ret;
    int          base;
  } frame_t;

  // reference model state
  logic [31:0] ds[$];
  frame_t      cs[$];
  logic [31:0] m_pc;
  bit          m_halt;

  function automatic logic [47:0] mk(logic [7:0] op, logic [31:0] arg);
    logic [7:0] fl;
    fl = 8'($urandom());
    return {op, fl, arg};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: hatch_address=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(logic [47:0] insn, logic [31:0] exp, string name);
    hatch_instruction = insn;
    @(posedge clk);
    #1;
    check(name, hatch_address, exp);
  endtask

  task automatic model_reset();
    ds.delete();
    cs.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
  endtask

  task automatic model_step(logic [47:0] ins);
    logic [7:0]  op;
    logic [31:0] arg, nxt, a, b, r;
    frame_t      fr;
    int          base;
    bit          flt;
    if (m_halt) return;
    op  = ins[47:40];
    arg = ins[31:0];
    nxt = m_pc + 32'd6;
    flt = 1'b0;
    case (op)
      PUSH: if (ds.size() >= 64) flt = 1; else ds.push_back(arg);
      POP:  if (ds.size() < 1) flt = 1; else void'(ds.pop_back());
      RET: begin
        if (cs.size() == 0) begin
          m_halt = 1'b1;
          return;
        end
        fr = cs[$];
        if (ds.size() <= fr.base) flt = 1;
        else begin
          r = ds[$];
          while (ds.size() > fr.base) void'(ds.pop_back());
          ds.push_back(r);
          void'(cs.pop_back());
          nxt = fr.ret;
        end
      end
      GOTO: nxt = arg;
      IFEQ, IFNE: begin
        if (ds.size() < 1) flt = 1;
        else begin
          a = ds.pop_back();
          if ((op == IFEQ) ? (a == 0) : (a != 0)) nxt = arg;
        end
      end
      ADD, SUB, BAND, BOR, BXOR, EQ, LT: begin
        if (ds.size() < 2) flt = 1;
        else begin
          b = ds.pop_back();
          a = ds.pop_back();
          case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            BAND:    r = a & b;
            BOR:     r = a | b;
            BXOR:    r = a ^ b;
            EQ:      r = (a == b) ? 1 : 0;
            default: r = ($signed(a) < $signed(b)) ? 1 : 0;
          endcase
          ds.push_back(r);
        end
      end
      DUP: begin
        if (ds.size() < 1 || ds.size() >= 64) flt = 1;
        else ds.push_back(ds[$]);
      end
      CALL: begin
        if ({32'd0, arg} >= 64'(ds.size())) flt = 1;
        else if (cs.size() >= 16) flt = 1;
        else begin
          base = ds.size() - int'(arg) - 1;
          fr.ret  = nxt;
          fr.base = base;
          cs.push_back(fr);
          nxt = ds[base];
        end
      end
      default: ;
    endcase
    if (flt) m_halt = 1'b1;
    else     m_pc = nxt;
  endtask

  function automatic logic [47:0] gen();
    int          k;
    logic [31:0] v;
    logic [7:0]  ops[7];
    logic [7:0]  odd[5];
    ops = '{ADD, SUB, BAND, BOR, BXOR, EQ, LT};
    odd = '{8'h03, 8'h04, 8'h09, 8'h20, 8'hFF};
    k = $urandom_range(0, 99);
    v = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
    if (k < 30) return mk(PUSH, v);
    if (k < 37) return mk(POP, v);
    if (k < 42) return mk(RET, v);
    if (k < 46) return mk(GOTO, $urandom());
    if (k < 52) return mk(($urandom_range(0, 1) != 0) ? IFEQ : IFNE, $urandom());
    if (k < 70) return mk(ops[$urandom_range(0, 6)], v);
    if (k < 76) return mk(DUP, v);
    if (k < 85) begin
      if ($urandom_range(0, 9) == 0) return mk(CALL, $urandom());
      return mk(CALL, 32'($urandom_range(0, 3)));
    end
    if (k < 90) return mk(NOP, v);
    return mk(odd[$urandom_range(0, 4)], v);
  endfunction

  task automatic do_reset();
    rst_b = 1'b0;
    #2;
    check("async_rst", hatch_address, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold", hatch_address, 32'h0);
    rst_b = 1'b1;
    model_reset();
  endtask

  vec_t        tbl[$];
  logic [47:0] ins;
  logic [31:0] pc;
  int          frozen;

  initial begin
    rst_b = 1'b0;
    hatch_instruction = 48'h0;
    model_reset();

    // reset held 27 ns, address must stay 0
    for (int i = 0; i < 3; i++) begin
      #7;
      check("reset_low", hatch_address, 32'h0);
    end
    #6;
    rst_b = 1'b1;
    #1;
    check("first_fetch", hatch_address, 32'h0);

    tbl.push_back('{mk(GOTO, 32'h7),        32'h7});
    tbl.push_back('{mk(PUSH, 32'h1001),     32'hD});
    tbl.push_back('{mk(PUSH, 32'h1337D00D), 32'h13});
    tbl.push_back('{mk(CALL, 32'h1),        32'h1001});
    tbl.push_back('{mk(PUSH, 32'h15410AAA), 32'h1007});
    tbl.push_back('{mk(RET,  32'h0),        32'h19});
    tbl.push_back('{mk(PUSH, 32'h15410AAA), 32'h1F});
    tbl.push_back('{mk(EQ,   32'h0),        32'h25});
    tbl.push_back('{mk(IFNE, 32'h40),       32'h40});
    tbl.push_back('{mk(PUSH, 32'h5),        32'h46});
    tbl.push_back('{mk(PUSH, 32'h3),        32'h4C});
    tbl.push_back('{mk(SUB,  32'h0),        32'h52});
    tbl.push_back('{mk(IFEQ, 32'h100),      32'h58});
    tbl.push_back('{mk(PUSH, 32'hF0),       32'h5E});
    tbl.push_back('{mk(PUSH, 32'h3C),       32'h64});
    tbl.push_back('{mk(BAND, 32'h0),        32'h6A});
    tbl.push_back('{mk(PUSH, 32'h30),       32'h70});
    tbl.push_back('{mk(EQ,   32'h0),        32'h76});
    tbl.push_back('{mk(IFNE, 32'h200),      32'h200});
    tbl.push_back('{mk(PUSH, 32'h1),        32'h206});
    tbl.push_back('{mk(ADD,  32'h0),        32'h206});
    tbl.push_back('{mk(NOP,  32'h0),        32'h206});
    tbl.push_back('{mk(PUSH, 32'h9),        32'h206});
    foreach (tbl[i]) step(tbl[i].insn, tbl[i].exp, $sformatf("vec%0d", i));

    // RETURN with empty call stack freezes the core
    do_reset();
    step(mk(GOTO, 32'h30), 32'h30, "goto30");
    step(mk(RET, 32'h0), 32'h30, "ret_empty");
    step(mk(NOP, 32'h0), 32'h30, "ret_frozen");
    do_reset();

    // IFEQ taken on zero
    step(mk(PUSH, 32'h0), 32'h6, "push0");
    step(mk(IFEQ, 32'h80), 32'h80, "ifeq_taken");

    // DS overflow on the 65th push
    do_reset();
    pc = 32'h0;
    for (int i = 0; i < 64; i++) begin
      pc = pc + 32'd6;
      step(mk(PUSH, 32'(i)), pc, "ds_fill");
    end
    step(mk(PUSH, 32'h1), pc, "ds_overflow");

    // CS overflow on the 17th call
    do_reset();
    pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      step(mk(PUSH, 32'h1000 * (i + 1)), pc + 32'd6, "cs_push");
      pc = 32'h1000 * (i + 1);
      step(mk(CALL, 32'h0), pc, "cs_call");
    end
    step(mk(PUSH, 32'h77000), pc + 32'd6, "cs_push17");
    pc = pc + 32'd6;
    step(mk(CALL, 32'h0), pc, "cs_overflow");

    // random bytecode against the model
    do_reset();
    frozen = 0;
    for (int c = 0; c < 4000; c++) begin
      if (m_halt) begin
        frozen++;
        if (frozen > 3) begin
          frozen = 0;
          do_reset();
          continue;
        end
      end
      ins = gen();
      hatch_instruction = ins;
      model_step(ins);
      @(posedge clk);
      #1;
      check("rand_pc", hatch_address, m_pc);
      if ($urandom_range(0, 199) == 0) begin
        frozen = 0;
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
